// File: rtl/fpga_instruction_scheduler.sv
// Instruction scheduler between the UART instruction encoder and the Neo chip command port.
// Buffers instructions in a FIFO, sequences each one to the chip, and returns one status byte per instruction.
module fpga_instruction_scheduler #(
    parameter int INSTR_W        = 147,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instruction_valid,
    input  logic [INSTR_W-1:0] instruction,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [3:0]         cmd_opcode,
    output logic [INSTR_W-5:0] cmd_payload,
    input  logic               chip_done,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    output logic               busy,
    output logic               overflow_err,
    output logic               timeout_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PAY_W = INSTR_W - 4;

    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [23:0]      TO_LAST   = 24'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_EXEC  = 4'h2;
    localparam logic [3:0] OP_CLEAR = 4'hF;

    localparam logic [7:0] ST_NOP     = 8'hA0;
    localparam logic [7:0] ST_WRITE   = 8'hA1;
    localparam logic [7:0] ST_EXEC    = 8'hA2;
    localparam logic [7:0] ST_CLEAR   = 8'hAF;
    localparam logic [7:0] ST_ILLEGAL = 8'hE1;
    localparam logic [7:0] ST_TIMEOUT = 8'hE3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         cmd_opcode_q, cmd_opcode_d;
    logic [PAY_W-1:0]   cmd_payload_q, cmd_payload_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [23:0]        to_cnt_q, to_cnt_d;
    logic               overflow_q, overflow_d;
    logic               timeout_q, timeout_d;
    logic [INSTR_W-1:0] fifo_mem_q [FIFO_DEPTH];

    logic               pop;
    logic               push_accept;
    logic [INSTR_W-1:0] head;

    assign head = fifo_mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d       = state_q;
        cmd_opcode_d  = cmd_opcode_q;
        cmd_payload_d = cmd_payload_q;
        tx_data_d     = tx_data_q;
        to_cnt_d      = to_cnt_q;
        overflow_d    = overflow_q;
        timeout_d     = timeout_q;
        pop           = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop           = 1'b1;
                    cmd_opcode_d  = head[INSTR_W-1 -: 4];
                    cmd_payload_d = head[PAY_W-1:0];
                    case (head[INSTR_W-1 -: 4])
                        OP_WRITE, OP_EXEC: state_d = ISSUE;
                        OP_NOP: begin
                            tx_data_d = ST_NOP;
                            state_d   = RESP;
                        end
                        OP_CLEAR: begin
                            overflow_d = 1'b0;
                            timeout_d  = 1'b0;
                            tx_data_d  = ST_CLEAR;
                            state_d    = RESP;
                        end
                        default: begin
                            tx_data_d = ST_ILLEGAL;
                            state_d   = RESP;
                        end
                    endcase
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    if (cmd_opcode_q == OP_EXEC) begin
                        to_cnt_d = '0;
                        state_d  = WAIT_DONE;
                    end else begin
                        tx_data_d = ST_WRITE;
                        state_d   = RESP;
                    end
                end
            end
            WAIT_DONE: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (chip_done) begin
                    tx_data_d = ST_EXEC;
                    state_d   = RESP;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    tx_data_d = ST_TIMEOUT;
                    state_d   = RESP;
                end else begin
                    to_cnt_d = to_cnt_q + 24'd1;
                end
            end
            RESP: begin
                if (tx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Fullness is judged after this cycle's pop, so full-plus-pop still accepts.
        push_accept = instruction_valid && !((count_q == FIFO_FULL) && !pop);
        if (instruction_valid && !push_accept) overflow_d = 1'b1;

        wr_ptr_d = wr_ptr_q + PTR_W'(push_accept);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push_accept) - CNT_W'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cmd_opcode_q  <= '0;
            cmd_payload_q <= '0;
            tx_data_q     <= '0;
            to_cnt_q      <= '0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cmd_opcode_q  <= cmd_opcode_d;
            cmd_payload_q <= cmd_payload_d;
            tx_data_q     <= tx_data_d;
            to_cnt_q      <= to_cnt_d;
            overflow_q    <= overflow_d;
            timeout_q     <= timeout_d;
        end
    end

    // NOTE: FIFO storage has no reset; the occupancy count guarantees stale entries are never read.
    always_ff @(posedge clk) begin
        if (push_accept) fifo_mem_q[wr_ptr_q] <= instruction;
    end

    assign cmd_valid    = (state_q == ISSUE);
    assign cmd_opcode   = cmd_opcode_q;
    assign cmd_payload  = cmd_payload_q;
    assign tx_valid     = (state_q == RESP);
    assign tx_data      = tx_data_q;
    assign busy         = (state_q != IDLE) || (count_q != '0);
    assign overflow_err = overflow_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_fpga_instruction_scheduler.sv
// Directed bench for fpga_instruction_scheduler: latency, EXEC completion/timeout, overflow,
// status ordering, TX back-pressure, full-FIFO push with pop, and asynchronous reset.
module tb_fpga_instruction_scheduler;

    localparam int INSTR_W = 147;
    localparam int PAY_W   = INSTR_W - 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               instruction_valid;
    logic [INSTR_W-1:0] instruction;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [3:0]         cmd_opcode;
    logic [PAY_W-1:0]   cmd_payload;
    logic               chip_done;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_ready;
    logic               busy;
    logic               overflow_err;
    logic               timeout_err;

    int total = 0;
    int bad   = 0;

    logic [7:0]  tx_q  [$];
    logic [15:0] cmd_q [$];
    int          cmd_valid_cyc = 0;

    fpga_instruction_scheduler #(
        .INSTR_W(INSTR_W),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instruction_valid(instruction_valid),
        .instruction(instruction),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_payload(cmd_payload),
        .chip_done(chip_done),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .busy(busy),
        .overflow_err(overflow_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Record accepted status bytes and command handshakes in arrival order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            if (cmd_valid && cmd_ready) cmd_q.push_back(cmd_payload[15:0]);
            if (cmd_valid) cmd_valid_cyc++;
        end
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input int unsigned pay);
        instruction_valid = 1'b1;
        instruction       = {op, PAY_W'(pay)};
        tick();
        instruction_valid = 1'b0;
    endtask

    task automatic wait_cmd(input string tag);
        int n = 0;
        while (!cmd_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_cmd_seen"}, cmd_valid, 1'b1);
    endtask

    task automatic wait_tx(input string tag);
        int n = 0;
        while (!tx_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_tx_seen"}, tx_valid, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic check_tx(input string tag, input logic [7:0] exp [$]);
        check({tag, "_tx_count"}, tx_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp[i]);
    endtask

    task automatic check_cmd(input string tag, input logic [15:0] exp [$]);
        check({tag, "_cmd_count"}, cmd_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_cmd%0d", tag, i), (i < cmd_q.size()) ? cmd_q[i] : 16'hxxxx, exp[i]);
    endtask

    // WRITE 0x1234 from an idle, empty scheduler: cmd_valid exactly at t+2, status at t+3.
    task automatic write_latency(input string tag);
        tx_q.delete();
        instruction_valid = 1'b1;
        instruction       = {4'h1, PAY_W'(32'h1234)};
        tick();
        instruction_valid = 1'b0;
        check({tag, "_t1_cmd_valid"}, cmd_valid, 1'b0);
        check({tag, "_t1_busy"}, busy, 1'b1);
        tick();
        check({tag, "_t2_cmd_valid"}, cmd_valid, 1'b1);
        check({tag, "_t2_opcode"}, cmd_opcode, 4'h1);
        check({tag, "_t2_payload"}, cmd_payload, PAY_W'(32'h1234));
        tick();
        check({tag, "_t3_cmd_valid"}, cmd_valid, 1'b0);
        check({tag, "_t3_tx_valid"}, tx_valid, 1'b1);
        check({tag, "_t3_tx_data"}, tx_data, 8'hA1);
        tick();
        check({tag, "_t4_tx_valid"}, tx_valid, 1'b0);
        check({tag, "_t4_busy"}, busy, 1'b0);
        check({tag, "_t4_tx_count"}, tx_q.size(), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n             = 1'b0;
        instruction_valid = 1'b0;
        instruction       = '0;
        cmd_ready         = 1'b1;
        chip_done         = 1'b0;
        tx_ready          = 1'b1;
        #12;
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_errs", {overflow_err, timeout_err}, 2'b00);
        check("rst_cmd_fields", {cmd_opcode, cmd_payload}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Scenario 1: WRITE latency and single-cycle handshakes.
        write_latency("s1");

        // Scenario 2a: EXEC completed by chip_done 10 cycles after the handshake.
        tx_q.delete();
        send(4'h2, 32'h22);
        wait_cmd("s2a");
        check("s2a_opcode", cmd_opcode, 4'h2);
        tick();
        repeat (9) tick();
        check("s2a_no_tx_yet", tx_valid, 1'b0);
        chip_done = 1'b1;
        tick();
        chip_done = 1'b0;
        check("s2a_tx_valid", tx_valid, 1'b1);
        check("s2a_tx_data", tx_data, 8'hA2);
        check("s2a_timeout_err", timeout_err, 1'b0);
        wait_idle("s2a");

        // Scenario 2b: EXEC with no completion times out after 16 cycles in WAIT_DONE.
        send(4'h2, 32'h33);
        wait_cmd("s2b");
        tick();
        n = 0;
        while (!tx_valid && n < 100) begin
            tick();
            n++;
        end
        check("s2b_wait_cycles", n, 16);
        check("s2b_tx_data", tx_data, 8'hE3);
        check("s2b_timeout_err", timeout_err, 1'b1);
        wait_idle("s2b");

        // Scenario 3: six pulses against a stalled chip; one is dropped.
        tx_q.delete();
        cmd_q.delete();
        cmd_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            instruction_valid = 1'b1;
            instruction       = {4'h1, PAY_W'(i)};
            tick();
        end
        instruction_valid = 1'b0;
        check("s3_overflow_err", overflow_err, 1'b1);
        check("s3_cmd_held", {cmd_valid, cmd_payload[15:0]}, {1'b1, 16'd1});
        repeat (3) tick();
        check("s3_cmd_stable", {cmd_valid, cmd_payload[15:0]}, {1'b1, 16'd1});
        cmd_ready = 1'b1;
        wait_idle("s3");
        check_cmd("s3", '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5});
        check_tx("s3", '{8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hA1});
        check("s3_timeout_sticky", timeout_err, 1'b1);
        tx_q.delete();
        send(4'hF, 0);
        wait_idle("s3_clear");
        check_tx("s3_clear", '{8'hAF});
        check("s3_clear_errs", {overflow_err, timeout_err}, 2'b00);

        // Scenario 4: NOP and an illegal opcode never reach the chip.
        tx_q.delete();
        cmd_valid_cyc = 0;
        send(4'h0, 0);
        send(4'h7, 32'h77);
        wait_idle("s4");
        check_tx("s4", '{8'hA0, 8'hE1});
        check("s4_cmd_valid_cycles", cmd_valid_cyc, 0);

        // Scenario 5: TX back-pressure holds the byte; fill the FIFO meanwhile,
        // then push into the full FIFO in the same cycle as a pop.
        tx_q.delete();
        cmd_q.delete();
        tx_ready = 1'b0;
        send(4'h0, 0);
        wait_tx("s5");
        for (int i = 0; i < 20; i++) begin
            check($sformatf("s5_hold_valid%0d", i), tx_valid, 1'b1);
            check($sformatf("s5_hold_data%0d", i), tx_data, 8'hA0);
            instruction_valid = (i < 4);
            instruction       = {4'h1, PAY_W'(32'h50 + i)};
            tick();
        end
        instruction_valid = 1'b0;
        check("s5_no_byte_during_hold", tx_q.size(), 0);
        tx_ready = 1'b1;
        tick();
        send(4'h1, 32'h55);
        check("s5_overflow_err", overflow_err, 1'b0);
        wait_idle("s5");
        check_cmd("s5", '{16'h50, 16'h51, 16'h52, 16'h53, 16'h55});
        check_tx("s5", '{8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hA1});

        // Scenario 6: asynchronous reset in the middle of WAIT_DONE.
        tx_q.delete();
        send(4'h2, 32'h66);
        wait_cmd("s6");
        tick();
        repeat (5) tick();
        check("s6_pre_busy", busy, 1'b1);
        check("s6_pre_opcode", cmd_opcode, 4'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_rst_cmd", {cmd_valid, cmd_opcode, cmd_payload}, '0);
        check("s6_rst_tx", {tx_valid, tx_data}, '0);
        check("s6_rst_status", {busy, overflow_err, timeout_err}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        chip_done = 1'b1;
        tick();
        chip_done = 1'b0;
        repeat (5) tick();
        check("s6_no_stale_byte", tx_q.size(), 0);
        check("s6_idle", {busy, tx_valid, cmd_valid}, 3'b000);
        write_latency("s6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpga_instruction_scheduler.md
Name: fpga_instruction_scheduler

Overview:
- Sits between the UART instruction encoder (147-bit word plus a 1-cycle valid pulse) and the Neo chip command interface.
- Buffers decoded instructions in a small FIFO, decodes the opcode, and sequences each command to the chip with a valid/ready handshake.
- For execute-type commands, waits for chip completion or a timeout.
- Returns a one-byte status per instruction to the PC via the UART TX path.

Parameters:
- INSTR_W, 147: instruction width; opcode is instruction[INSTR_W-1 -: 4], payload is the remaining INSTR_W-4 bits.
- FIFO_DEPTH, 4: instruction FIFO entries; must be a power of 2, ≥2.
- TIMEOUT_CYCLES, 1000000: maximum clk cycles in WAIT_DONE before aborting; range 1 to 2^24-1.

Ports:
- clk, input, 1: single system clock.
- rst_n, input, 1: asynchronous active-low reset.
- instruction_valid, input, 1: single-cycle pulse; instruction is valid this cycle.
- instruction, input, INSTR_W: assembled instruction word.
- cmd_valid, output, 1: command is presented to the chip.
- cmd_ready, input, 1: chip accepts the command when cmd_valid && cmd_ready.
- cmd_opcode, output, 4: opcode of the current command.
- cmd_payload, output, INSTR_W-4: payload of the current command.
- chip_done, input, 1: chip completion pulse for EXEC commands.
- tx_valid, output, 1: status byte is valid.
- tx_data, output, 8: status byte.
- tx_ready, input, 1: UART TX accepts the byte when tx_valid && tx_ready.
- busy, output, 1: high when the FSM is not in IDLE or the FIFO is non-empty.
- overflow_err, output, 1: sticky; an instruction was dropped because the FIFO was full.
- timeout_err, output, 1: sticky; an EXEC command timed out.

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty, FSM in IDLE, timeout counter at 0.
  - Outputs: cmd_valid=0, cmd_opcode=0, cmd_payload=0, tx_valid=0, tx_data=0, busy=0, overflow_err=0, timeout_err=0.
  - Reset mid-operation discards the FIFO contents and any in-flight command, and sends no status byte.
- FIFO push: on instruction_valid.
  - Fullness is evaluated after the same-cycle pop, so a push into a full FIFO with a simultaneous pop is accepted.
  - A push into a full FIFO with no pop is dropped and sets overflow_err.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter of width log2(FIFO_DEPTH)+1 tracks fullness.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE: if the FIFO is non-empty, pop the head into the command register at this edge. Next state by opcode:
  - 0x1 WRITE, 0x2 EXEC: go to ISSUE.
  - 0x0 NOP: go to RESP with status 0xA0.
  - 0xF CLEAR: clear overflow_err and timeout_err, go to RESP with status 0xAF.
  - any other opcode: go to RESP with status 0xE1 (illegal).
- ISSUE: cmd_valid=1; cmd_opcode and cmd_payload are held stable until the handshake.
  - On cmd_valid && cmd_ready: cmd_valid drops next cycle.
  - WRITE goes to RESP with status 0xA1.
  - EXEC goes to WAIT_DONE and clears the timeout counter.
- WAIT_DONE:
  - The counter increments each cycle.
  - chip_done goes to RESP with status 0xA2. chip_done wins over a simultaneous timeout.
  - When the counter reaches TIMEOUT_CYCLES-1 without chip_done: set timeout_err, go to RESP with status 0xE3.
  - chip_done outside WAIT_DONE is ignored.
- RESP: tx_valid=1 and tx_data is held stable until tx_valid && tx_ready, then return to IDLE.
- Latency, instruction_valid pulse to cmd_valid high, with empty FIFO and FSM in IDLE: pulse at cycle t, FIFO write at edge t, pop at edge t+1, cmd_valid high from cycle t+2.
- Throughput: one instruction in flight at a time. Minimum cycles per WRITE is 3 (pop, issue, resp) with ready signals held high.
- Ordering: status bytes are emitted strictly in instruction arrival order. Exactly one byte per accepted instruction; no byte for dropped instructions.
- busy is combinational from the state and FIFO occupancy.

Test Plan:
1. Reset, then a WRITE pulse (opcode 0x1, payload 0x1234), cmd_ready=1, tx_ready=1 -> cmd_valid high exactly at t+2 with payload 0x1234 for 1 cycle; tx_data=0xA1 for 1 cycle; busy then returns to 0.
2. EXEC (0x2) with chip_done pulsed 10 cycles after the handshake -> tx_data=0xA2. Repeat with TIMEOUT_CYCLES=16 and no chip_done -> tx_data=0xE3 after 16 cycles in WAIT_DONE; timeout_err=1.
3. cmd_ready=0 while 6 pulses arrive (FIFO_DEPTH=4) -> 4 instructions are held in the FIFO, 1 is in the command register, 1 is dropped with overflow_err=1. Release cmd_ready -> 5 status bytes arrive in order. A following CLEAR (0xF) -> byte 0xAF; overflow_err=0 and timeout_err=0.
4. Opcodes 0x0 and 0x7 -> bytes 0xA0 then 0xE1; cmd_valid never asserts.
5. tx_ready held low for 20 cycles in RESP -> tx_valid and tx_data stay stable. A push arriving while the FIFO is full and a pop occurs in the same cycle is accepted, with no overflow.
6. rst_n asserted low mid-WAIT_DONE -> all outputs read 0 immediately (asynchronously). After release, no stale status byte appears and the next instruction behaves as in scenario 1.
